// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the two-requester RAM port arbiter: FSM states, owner ids
// and default RAM geometry.
package ram_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  function automatic logic other_owner(input logic owner);
    return (owner == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-input round-robin pick. Purely combinational; the parent registers the result
// when it leaves IDLE.
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_owner,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = a_req | b_req;
    pick  = OWN_A;
    if (a_req && b_req) begin
      pick = other_owner(last_owner);
    end else if (b_req) begin
      pick = OWN_B;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises two requesters onto one synchronous-read 16x4 RAM port and returns
// captured read data with a one-cycle done pulse per access.
//
// state   | meaning
// IDLE    | waiting for a request; arbitration happens here only
// ACCESS  | owner's address/data/we presented to the RAM
// CAPTURE | RAM output reflects registered address; read data latched at end
// DONE    | owner's done pulse; last_owner updated
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,

  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  logic [1:0] state;
  logic       owner;
  logic       last_owner;
  logic       lat_we;
  logic       ram_we_r;
  logic       arb_valid;
  logic       arb_pick;

  rr_arbiter2 u_arb (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_owner (last_owner),
    .valid      (arb_valid),
    .pick       (arb_pick)
  );

  // Reset must also suppress a write whose RAM edge coincides with reset assertion.
  assign ram_we = ram_we_r & reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_A;
      last_owner <= OWN_B;
      lat_we     <= 1'b0;
      ram_we_r   <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            owner <= arb_pick;
            state <= ST_ACCESS;
            if (arb_pick == OWN_A) begin
              lat_we   <= a_we;
              ram_we_r <= a_we;
              ram_addr <= a_addr;
              ram_data <= a_wdata;
              a_gnt    <= 1'b1;
            end else begin
              lat_we   <= b_we;
              ram_we_r <= b_we;
              ram_addr <= b_addr;
              ram_data <= b_wdata;
              b_gnt    <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          ram_we_r <= 1'b0;
          state    <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!lat_we) begin
            if (owner == OWN_A) a_rdata <= ram_q;
            else                b_rdata <= ram_q;
          end
          a_gnt  <= 1'b0;
          b_gnt  <= 1'b0;
          a_done <= (owner == OWN_A);
          b_done <= (owner == OWN_B);
          state  <= ST_DONE;
        end
        default: begin
          last_owner <= owner;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural 16x4 registered-address RAM.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic       a_gnt, a_done, b_gnt, b_done, ram_we;
  logic [3:0] a_rdata, b_rdata, ram_addr, ram_data, ram_q;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  function automatic logic [3:0] init_val(input logic [3:0] a);
    case (a)
      4'd0:    return 4'h1;
      4'd1:    return 4'hA;
      4'd5:    return 4'h1;
      default: return 4'(a * 3 + 2);
    endcase
  endfunction

  // RAM model: write on the edge, address registered, output from registered address.
  logic [3:0] ram_mem [16];
  logic [3:0] ram_addr_q = '0;
  logic       load_mem = 1'b0;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= init_val(4'(i));
      ram_addr_q <= '0;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      ram_addr_q <= ram_addr;
    end
  end
  assign ram_q = ram_mem[ram_addr_q];

  int cyc_cnt = 0;
  int we_cycles = 0;
  always @(posedge clk) begin
    cyc_cnt++;
    if (ram_we) we_cycles++;
  end

  typedef struct {
    logic       who;
    logic       we;
    logic [3:0] rdata;
  } exp_t;
  exp_t       sb[$];
  logic [3:0] exp_mem [16];
  int vectors = 0;
  int miscompares = 0;

  task automatic model_init();
    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(4'(i));
    sb.delete();
  endtask

  task automatic issue(input logic who, input logic we, input logic [3:0] addr,
                       input logic [3:0] wd);
    exp_t e;
    if (who == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
    e.who = who;
    e.we = we;
    e.rdata = we ? 4'h0 : exp_mem[addr];
    if (we) exp_mem[addr] = wd;
    sb.push_back(e);
  endtask

  // Returns cyc_cnt at the done cycle, or -1 on timeout.
  task automatic wait_done(input int budget, output int stamp, output logic who,
                           output logic [3:0] rd);
    bit seen = 0;
    stamp = -1; who = 1'b0; rd = 4'h0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (a_done || b_done) begin
        seen = 1;
        stamp = cyc_cnt;
        who = b_done;
        rd = b_done ? b_rdata : a_rdata;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; load_mem = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    model_init();
    repeat (2) @(negedge clk);
    load_mem = 1'b0; reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int we0, t0, st;
    logic who;
    logic [3:0] rd;
    exp_t e;
    reset_n = 1'b0; load_mem = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wdata = 4'h5;
    model_init();
    we0 = we_cycles;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({a_gnt, b_gnt, a_done, b_done, ram_we} !== 5'b0 || ram_addr !== 4'h0 ||
          ram_data !== 4'h0 || a_rdata !== 4'h0 || b_rdata !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: gnt=%b%b done=%b%b we=%b addr=%h data=%h rd=%h/%h, required all 0",
                 a_gnt, b_gnt, a_done, b_done, ram_we, ram_addr, ram_data, a_rdata, b_rdata);
      end
    end
    vectors++;
    if (we_cycles != we0) begin
      miscompares++;
      $display("FAIL reset_no_we: we cycles=%0d, required 0", we_cycles - we0);
    end
    load_mem = 1'b0; reset_n = 1'b1;
    issue(1'b0, 1'b0, 4'd2, 4'h0);
    t0 = cyc_cnt;
    wait_done(8, st, who, rd);
    a_req = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (st != t0 + 3 || who !== e.who || rd !== e.rdata) begin
      miscompares++;
      $display("FAIL reset_first_grant: lat=%0d who=%0d rd=%h, required lat=3 who=%0d rd=%h",
               st - t0, who, rd, e.who, e.rdata);
    end
  endtask

  task automatic test_write_read();
    int we0, t0, st;
    logic who;
    logic [3:0] rd;
    exp_t e;
    @(negedge clk);
    we0 = we_cycles;
    issue(1'b0, 1'b1, 4'd3, 4'hA);
    t0 = cyc_cnt;
    @(negedge clk);
    vectors++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 4'd3 || ram_data !== 4'hA) begin
      miscompares++;
      $display("FAIL wr_access: gnt=%b%b we=%b addr=%h data=%h, required gnt=10 we=1 addr=3 data=a",
               a_gnt, b_gnt, ram_we, ram_addr, ram_data);
    end
    @(negedge clk);
    vectors++;
    if (a_gnt !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 4'd3) begin
      miscompares++;
      $display("FAIL wr_capture: gnt=%b we=%b addr=%h, required gnt=1 we=0 addr=3", a_gnt, ram_we, ram_addr);
    end
    wait_done(4, st, who, rd);
    a_req = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (st != t0 + 3 || who !== e.who || a_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_done: lat=%0d who=%0d gnt=%b, required lat=3 who=%0d gnt=0", st - t0, who, a_gnt, e.who);
    end
    @(negedge clk);
    issue(1'b0, 1'b0, 4'd3, 4'h0);
    wait_done(8, st, who, rd);
    a_req = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (st != t0 + 7 || who !== e.who || rd !== e.rdata) begin
      miscompares++;
      $display("FAIL wr_then_rd: span=%0d who=%0d rd=%h, required span=7 who=%0d rd=%h",
               st - t0, who, rd, e.who, e.rdata);
    end
    vectors++;
    if (we_cycles - we0 != 1) begin
      miscompares++;
      $display("FAIL wr_we_count: we cycles=%0d, required 1", we_cycles - we0);
    end
  endtask

  task automatic test_tie();
    int t0, st;
    logic who;
    logic [3:0] rd;
    exp_t e;
    do_reset();
    issue(1'b0, 1'b0, 4'd0, 4'h0);
    issue(1'b1, 1'b0, 4'd1, 4'h0);
    issue(1'b0, 1'b0, 4'd0, 4'h0);
    t0 = cyc_cnt;
    @(negedge clk);
    vectors++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_first_gnt: gnt=%b%b, required 10", a_gnt, b_gnt);
    end
    for (int k = 0; k < 3; k++) begin
      wait_done(10, st, who, rd);
      e = sb.pop_front();
      vectors++;
      if (st != t0 + 3 + 4 * k || who !== e.who || rd !== e.rdata) begin
        miscompares++;
        $display("FAIL tie_grant%0d: t=%0d who=%0d rd=%h, required t=%0d who=%0d rd=%h",
                 k, st - t0, who, rd, 3 + 4 * k, e.who, e.rdata);
      end
      if (k == 1) begin
        vectors++;
        if (a_rdata !== 4'h1) begin
          miscompares++;
          $display("FAIL tie_hold_a: a_rdata=%h, required 1", a_rdata);
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_cross();
    int t0, st;
    logic who;
    logic [3:0] rd;
    exp_t e;
    @(negedge clk);
    issue(1'b1, 1'b1, 4'd15, 4'hC);
    wait_done(8, st, who, rd);
    b_req = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (who !== e.who) begin
      miscompares++;
      $display("FAIL cross_wr: who=%0d, required %0d", who, e.who);
    end
    issue(1'b0, 1'b0, 4'd15, 4'h0);
    t0 = cyc_cnt;
    wait_done(8, st, who, rd);
    a_req = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (st != t0 + 4 || who !== e.who || rd !== e.rdata) begin
      miscompares++;
      $display("FAIL cross_rd: lat=%0d who=%0d rd=%h, required lat=4 who=%0d rd=%h",
               st - t0, who, rd, e.who, e.rdata);
    end
  endtask

  task automatic test_change_after_accept();
    int st;
    logic who;
    logic [3:0] rd;
    exp_t e;
    @(negedge clk);
    issue(1'b0, 1'b0, 4'd5, 4'h0);
    @(negedge clk);
    a_addr = 4'd7; a_req = 1'b0;
    vectors++;
    if (ram_addr !== 4'd5 || a_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL chg_access: addr=%h gnt=%b, required addr=5 gnt=1", ram_addr, a_gnt);
    end
    @(negedge clk);
    vectors++;
    if (ram_addr !== 4'd5 || a_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL chg_capture: addr=%h gnt=%b, required addr=5 gnt=1", ram_addr, a_gnt);
    end
    wait_done(4, st, who, rd);
    e = sb.pop_front();
    vectors++;
    if (st < 0 || who !== e.who || rd !== e.rdata) begin
      miscompares++;
      $display("FAIL chg_done: t=%0d who=%0d rd=%h, required done who=%0d rd=%h", st, who, rd, e.who, e.rdata);
    end
  endtask

  task automatic test_reset_mid();
    int dones, st;
    logic who;
    logic [3:0] rd;
    exp_t e;
    repeat (2) @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd4;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (b_gnt !== 1'b1 || b_rdata !== 4'hA) begin
      miscompares++;
      $display("FAIL mid_pre: b_gnt=%b b_rdata=%h, required 1 a", b_gnt, b_rdata);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; b_req = 1'b0;
    vectors++;
    if (b_gnt !== 1'b0 || b_done !== 1'b0 || b_rdata !== 4'h0) begin
      miscompares++;
      $display("FAIL mid_abort: gnt=%b done=%b rd=%h, required 0 0 0", b_gnt, b_done, b_rdata);
    end
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (b_done || a_done) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL mid_no_done: dones=%0d, required 0", dones);
    end
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd6; b_wdata = 4'hF;
    @(negedge clk);
    vectors++;
    if (b_gnt !== 1'b1 || ram_we !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_wr_pre: gnt=%b we=%b, required 1 1", b_gnt, ram_we);
    end
    reset_n = 1'b0; b_req = 1'b0;
    #1;
    vectors++;
    if (ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_wr_we: ram_we=%b, required 0", ram_we);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 1'b0, 4'd6, 4'h0);
    wait_done(8, st, who, rd);
    a_req = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (st < 0 || who !== e.who || rd !== e.rdata) begin
      miscompares++;
      $display("FAIL abort_wr_rd: t=%0d who=%0d rd=%h, required done who=%0d rd=%h", st, who, rd, e.who, e.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_cross();
    test_change_after_accept();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
